// File: rtl/lsu_ctrl.sv
// Load/store unit: splits byte-addressed requests into word accesses, read-modify-write for
// sub-word stores. Optional macro LSU_MISALIGN_TRAP_EN reports misaligned requests instead.
module lsu_ctrl #(
  parameter int unsigned IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_funct3_i,
  input  logic        req_store_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  typedef enum logic [2:0] {StIdle, StRdLo, StRdHi, StWrLo, StWrHi, StResp} state_e;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic spans(input logic [2:0] f3, input logic [1:0] off);
    return ({1'b0, off} + size_of(f3)) > 3'd4;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic [2:0] sz;
    sz = size_of(f3);
    return ((sz == 3'd2) && off[0]) || ((sz == 3'd4) && (off != 2'b00));
  endfunction

  state_e          state_q, state_d;
  logic [2:0]      f3_q;
  logic            store_q;
  logic [IDX_W+1:0] addr_q;
  logic [31:0]     wdata_q;
  logic [63:0]     buf_q, buf_d;
  logic            accept;

  // Bits above the word index are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr_i[31:IDX_W+2];

  assign accept = req_valid_i && (state_q == StIdle);

  logic [1:0]       off;
  logic [IDX_W-1:0] lo, hi;
  logic [2:0]       size;
  logic             span;

  assign off  = addr_q[1:0];
  assign lo   = addr_q[IDX_W+1:2];
  assign hi   = lo + IDX_W'(1);
  assign size = size_of(f3_q);
  assign span = spans(f3_q, off);

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned(req_funct3_i, req_addr_i[1:0]);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      f3_q    <= 3'b000;
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      buf_q   <= 64'h0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      if (accept) begin
        f3_q    <= req_funct3_i;
        store_q <= req_store_i;
        addr_q  <= req_addr_i[IDX_W+1:0];
        wdata_q <= req_wdata_i;
      end
    end
  end

  // Store merge: byte enables over the 64-bit lo/hi window.
  logic [7:0]  byte_en;
  logic [63:0] mask64, data64, merged;

  always_comb begin
    case (size)
      3'd1:    byte_en = 8'h01;
      3'd2:    byte_en = 8'h03;
      default: byte_en = 8'h0F;
    endcase
    byte_en = byte_en << off;
    for (int i = 0; i < 8; i++) begin
      mask64[i*8 +: 8] = {8{byte_en[i]}};
    end
    data64 = {32'h0, wdata_q} << {off, 3'b000};
    merged = (buf_q & ~mask64) | (data64 & mask64);
  end

  // Load extract and extension.
  logic [31:0] raw, ext;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      raw[i*8 +: 8] = buf_q[(int'(off) + i)*8 +: 8];
    end
    case (f3_q)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  ext = {24'h0, raw[7:0]};
      3'b101:  ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end

  // Next state.
  always_comb begin
    logic trap_req;
    state_d  = state_q;
    trap_req = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap_req = misaligned(req_funct3_i, req_addr_i[1:0]);
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (trap_req) begin
            state_d = StResp;
          end else if (req_store_i && (size_of(req_funct3_i) == 3'd4)
                       && (req_addr_i[1:0] == 2'b00)) begin
            state_d = StWrLo;
          end else begin
            state_d = StRdLo;
          end
        end
      end
      StRdLo: begin
        if (span)         state_d = StRdHi;
        else if (store_q) state_d = StWrLo;
        else              state_d = StResp;
      end
      StRdHi:  state_d = store_q ? StWrLo : StResp;
      StWrLo:  state_d = span ? StWrHi : StResp;
      StWrHi:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from state so reset clears them asynchronously.
  always_comb begin
    buf_d       = buf_q;
    req_ready_o = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    mem_we_o    = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = 32'h0;
    rsp_err_o   = 1'b0;
    unique case (state_q)
      StIdle: req_ready_o = 1'b1;
      StRdLo: begin
        mem_addr_o  = 32'(lo);
        buf_d[31:0] = mem_rdata_i;
      end
      StRdHi: begin
        mem_addr_o   = 32'(hi);
        buf_d[63:32] = mem_rdata_i;
      end
      StWrLo: begin
        mem_addr_o  = 32'(lo);
        mem_we_o    = 1'b1;
        mem_wdata_o = merged[31:0];
      end
      StWrHi: begin
        mem_addr_o  = 32'(hi);
        mem_we_o    = 1'b1;
        mem_wdata_o = merged[63:32];
      end
      StResp: begin
        rsp_valid_o = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        rsp_err_o   = err_q;
        rsp_rdata_o = (store_q || err_q) ? 32'h0 : ext;
`else
        rsp_rdata_o = store_q ? 32'h0 : ext;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit between the core's execute stage and the word-organised data memory.
- Accepts byte-addressed load/store requests (byte, half, word; signed and unsigned loads).
- Converts each request into one or more word-indexed memory accesses. Sub-word stores use read-modify-write, because the memory has only a full-word write enable.
- Returns load data sign/zero-extended with a one-cycle response pulse. Little-endian throughout.

Parameters:
- IDX_W, 8, width of the memory word index. Index = byte_addr[IDX_W+1:2]; byte-address bits above IDX_W+1 are ignored.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on a clk edge with req_valid && req_ready
- req_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; other codes treated as word size
- req_store  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- mem_addr  out  32  word index to memory; bits [31:IDX_W] are zero
- mem_wdata  out  32  write data to memory
- mem_we  out  1  memory write enable
- mem_rdata  in  32  combinational read data from memory at mem_addr
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  misalignment error flag, valid with rsp_valid

Behaviour:
- Reset values: req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; FSM in IDLE.
- On accept, latch funct3, store, addr and wdata. Define:
  - size = 1/2/4
  - off = addr[1:0]
  - lo = addr[IDX_W+1:2]
  - hi = lo+1 modulo 2^IDX_W (index wraps, e.g. 255 -> 0)
  - span = (off+size > 4)
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, RESP.
- Load path: IDLE -> RD_LO -> (RD_HI if span) -> RESP.
- SW, aligned: IDLE -> WR_LO -> RESP.
- SB, SH, or misaligned SW: IDLE -> RD_LO -> (RD_HI if span) -> WR_LO -> (WR_HI if span) -> RESP.
- RD_x states:
  - mem_addr = lo or hi, mem_we=0.
  - mem_rdata is captured into an internal 64-bit buffer at the end of the cycle: lo word in bits [31:0], hi word in bits [63:32].
- WR_x states:
  - mem_we=1 for exactly that cycle, mem_addr = lo or hi.
  - mem_wdata = buffered word with the store bytes merged in at byte positions off..off+size-1 of the 64-bit buffer.
  - Untouched bytes are preserved.
- RESP state:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - Loads: rsp_rdata = buffer bytes off..off+size-1. LB/LH sign-extend; LBU/LHU zero-extend; LW passes 32 bits.
- Latency from the accept edge to the rsp_valid cycle:
  - aligned load: 2
  - spanning load: 3
  - aligned SW: 2
  - aligned SB/SH: 3
  - spanning store: 5
- rsp_valid has no backpressure; the consumer must take it.
- mem_we is never high outside WR_LO/WR_HI.
- req_ready=0 from accept until return to IDLE. The next request can be accepted in the cycle after RESP.
- Reset mid-operation: immediate return to IDLE, mem_we deasserted asynchronously, no response. Writes already committed stay in memory; pending writes never occur.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- When defined: a request not naturally aligned (half with addr[0]=1; word with off!=0) issues no memory access. FSM goes IDLE -> RESP with rsp_err=1 and rsp_rdata=0, latency 1.
- When undefined: misaligned accesses are split as above, and rsp_err is tied to 0.

Test Plan:
- Memory preloaded so word i = i; LW addr 0x08 -> single RD_LO on index 2, rsp_valid 2 cycles after accept, rsp_rdata=0x00000002, rsp_err=0.
- SW 0x0C wdata 0xDEADBEEF -> one mem_we cycle at index 3, word3=0xDEADBEEF. Then:
  - LB 0x0F -> 0xFFFFFFDE
  - LBU 0x0D -> 0x000000BE
  - LH 0x0E -> 0xFFFFDEAD
  - LHU 0x0C -> 0x0000BEEF
- SB 0x11 wdata 0x000000AA with word4=4 -> RD_LO then WR_LO at index 4, word4=0x0000AA04, latency 3.
- Macro undefined, word3=0xDEADBEEF, word4=0x0000AA04; LW 0x0E -> reads of index 3 and 4, rsp_rdata=0xAA04DEAD, latency 3. Macro defined: same request -> no mem access, rsp_err=1 one cycle after accept.
- Wrap, macro undefined: SH 0x3FF wdata 0x1234 -> word255[31:24]=0x34, word0[7:0]=0x12, all other bytes of both words unchanged, latency 5.
- Misaligned SW 0x0E in progress; assert rst during RD_HI -> mem_we never asserted, words 3/4 unchanged, no rsp_valid, req_ready=1 after reset.
